// File: rtl/fsa_mul_arbiter.sv
// Round-robin front end that time-shares one combinational FSA multiplier
// between N_REQ requesters; operands are held for SETTLE_CYCLES before capture.
module fsa_mul_arbiter #(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = 24,
  parameter int SETTLE_CYCLES = 2,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [2*WIDTH-1:0]       resp_result,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_result,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t                        state;
  logic [IDW-1:0]                rr_ptr;
  logic [CW-1:0]                 cnt;
  logic [N_REQ-1:0][WIDTH-1:0]   op_a, op_b;
  logic [IDW-1:0]                win, idx, nxt_ptr;
  logic                          found;

  assign op_a = req_a;
  assign op_b = req_b;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[win] = 1'b1;
  end

  assign nxt_ptr = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          mul_a   <= op_a[win];
          mul_b   <= op_b[win];
          resp_id <= win;
          rr_ptr  <= nxt_ptr;
          cnt     <= CW'(SETTLE_CYCLES - 1);
          state   <= SETTLE;
        end
        // mul_a/mul_b stay frozen here so the FSA output can settle.
        SETTLE: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          resp_result <= mul_result;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsa_mul_arbiter.sv
// Bench for fsa_mul_arbiter: table vectors plus hand sequences for arbitration,
// back-pressure and mid-operation reset; responses checked against a queue.
module tb_fsa_mul_arbiter;
  localparam int N = 4, W = 24, S = 2;

  logic             clk = 1'b0, rst = 1'b0;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic             resp_valid, resp_ready, busy;
  logic [1:0]       resp_id;
  logic [2*W-1:0]   resp_result, mul_result;
  logic [W-1:0]     mul_a, mul_b;

  fsa_mul_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .busy(busy));

  always #5 clk = ~clk;

  // Stand-in for the external FSA block.
  assign mul_result = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [47:0] res; int acc; } exp_t;
  exp_t q[$];

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [47:0] res; } vec_t;
  vec_t tbl[7];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Waits (bounded) for a grant, checks it is the expected one-hot, rides the accept edge.
  task automatic grant(input int id, input logic [47:0] res, input bit track);
    int t = 0;
    while (req_ready == '0 && t < 40) begin
      @(negedge clk); #1; t++;
    end
    chk($sformatf("grant%0d", id), 64'(req_ready), 64'(1) << id);
    if (req_ready[id] && track) q.push_back('{id, res, cyc});
    @(posedge clk); #1;
  endtask

  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [47:0] res, input bit track);
    @(negedge clk);
    put(id, a, b);
    req_valid[id] = 1'b1;
    #1;
    grant(id, res, track);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk); t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  // Response monitor: latency on the rising edge of resp_valid, payload on handshake.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) prev_v = 1'b0;
    else begin
      if (resp_valid && !prev_v) begin
        if (q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - q[0].acc), 64'(S + 1));
      end
      if (resp_valid && resp_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_result", 64'(resp_result), 64'(e.res));
      end
      prev_v = resp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] oa[N], ob[N];
  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    tbl[0] = '{0, 24'd3,       24'd5,       48'd15};
    tbl[1] = '{1, 24'hFFFFFF,  24'hFFFFFF,  48'hFFFFFE000001};
    tbl[2] = '{2, 24'h000000,  24'hABCDEF,  48'h0};
    tbl[3] = '{3, 24'hABCDEF,  24'h000001,  48'hABCDEF};
    tbl[4] = '{1, 24'h001000,  24'h001000,  48'h1000000};
    tbl[5] = '{0, 24'h800000,  24'h000002,  48'h1000000};
    tbl[6] = '{3, 24'h123456,  24'h000010,  48'h1234560};

    #1;
    chk("reset_ctl", 64'({req_ready, resp_valid, resp_id, busy}), 64'd0);
    chk("reset_mul", 64'({mul_a, mul_b}), 64'd0);
    chk("reset_res", 64'(resp_result), 64'd0);
    #20;
    @(negedge clk) rst = 1'b1;

    // Table vectors, one requester at a time
    for (int k = 0; k < 7; k++) single(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].res, 1'b1);
    drain();
    chk("mul_hold", 64'({mul_a, mul_b}), 64'({24'h123456, 24'h000010}));

    // All requesters valid from rr_ptr=0: order 0,1,2,3,0; operands change after each accept
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); put(i, oa[i], ob[i]);
    end
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      grant(order[g], 48'(oa[order[g]]) * 48'(ob[order[g]]), 1'b1);
      oa[order[g]] = W'($urandom); ob[order[g]] = W'($urandom);
      put(order[g], oa[order[g]], ob[order[g]]);
    end
    req_valid = '0;
    drain();

    // Grant to 2, then 0 and 3 pending: 3 first, then 0
    single(2, 24'd1000, 24'd1000, 48'd1000000, 1'b1);
    @(negedge clk);
    put(0, 24'd12, 24'd34); put(3, 24'd56, 24'd78);
    req_valid = 4'b1001;
    #1;
    grant(3, 48'd4368, 1'b1);
    req_valid[3] = 1'b0;
    grant(0, 48'd408, 1'b1);
    req_valid[0] = 1'b0;
    drain();

    // Back-pressure: response held, no grants while waiting
    resp_ready = 1'b0;
    single(1, 24'd7, 24'd9, 48'd63, 1'b1);
    put(2, 24'd20, 24'd30);
    req_valid[2] = 1'b1;
    begin
      int t = 0;
      while (!resp_valid && t < 20) begin @(negedge clk); t++; end
    end
    chk("resp_wait", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_id", 64'(resp_id), 64'd1);
      chk("hold_res", 64'(resp_result), 64'd63);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #2 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("release_busy", 64'(busy), 64'd0);
    chk("release_valid", 64'(resp_valid), 64'd0);
    grant(2, 48'd600, 1'b1);
    req_valid[2] = 1'b0;
    drain();

    // Reset while settling: nothing comes back, rr_ptr returns to 0
    single(1, 24'd11, 24'd13, 48'd143, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("midrst_ctl", 64'({req_ready, resp_valid, resp_id, busy}), 64'd0);
    chk("midrst_mul", 64'({mul_a, mul_b}), 64'd0);
    chk("midrst_res", 64'(resp_result), 64'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    put(1, 24'd21, 24'd2); put(3, 24'd5, 24'd5);
    req_valid = 4'b1010;
    #1;
    grant(1, 48'd42, 1'b1);
    req_valid[1] = 1'b0;
    grant(3, 48'd25, 1'b1);
    req_valid[3] = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
